mips_processor: RTL and testbench

MIPS_PROCESSOR -- requirements
Module: mips_processor

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mips_imem.sv | 14 +
 rtl/mips_regfile.sv | 29 ++
 rtl/mips_processor.sv | 177 +++++++++++++++++
 tb/tb_mips_processor.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants, ALU operation enum and decoded control bundle
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_LUI
   } alu_op_e;

   typedef struct packed {
      logic    reg_we;
      logic    dst_rd;
      logic    use_imm;
      logic    zext_imm;
      logic    mem_we;
      logic    mem_to_reg;
      logic    beq;
      logic    bne;
      logic    jump;
      alu_op_e alu_op;
   } ctrl_t;

endpackage

// File: rtl/mips_imem.sv
// rtl/mips_imem.sv - instruction memory, combinational read; contents are loaded from outside the core
module mips_imem #(
   parameter int  WORDS = 1024,
   localparam int AW    = $clog2(WORDS)
) (
   input  logic [AW-1:0] addr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] memory [0:WORDS-1];

   assign rdata_o = memory[addr_i];

endmodule

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 register file, two combinational read ports, $0 hardwired to zero
module mips_regfile (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);

   logic [31:0] registers [0:31];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) begin
            registers[i] <= '0;
         end
      end else if (we_i && (wa_i != 5'd0)) begin
         registers[wa_i] <= wd_i;
      end
   end

   assign rd1_o = (ra1_i == 5'd0) ? 32'h0 : registers[ra1_i];
   assign rd2_o = (ra2_i == 5'd0) ? 32'h0 : registers[ra2_i];

endmodule

// File: rtl/mips_processor.sv
// rtl/mips_processor.sv - single-cycle MIPS subset core: inline decoder, ALU and data memory
module mips_processor
   import mips_pkg::*;
#(
   parameter int IMEM_WORDS = 1024,
   parameter int DMEM_WORDS = 256
) (
   input logic clk,
   input logic reset
);

   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   logic [31:0]    pc_reg;
   logic [31:0]    pc_d;
   logic [31:0]    pc_plus4;
   logic [31:0]    instruction;
   ctrl_t          ctrl;
   logic [5:0]     opcode;
   logic [5:0]     funct;
   logic [4:0]     rs;
   logic [4:0]     rt;
   logic [4:0]     rd;
   logic [4:0]     shamt;
   logic [15:0]    imm;
   logic [31:0]    imm_ext;
   logic [31:0]    rs_val;
   logic [31:0]    rt_val;
   logic [31:0]    alu_b;
   logic [31:0]    alu_res;
   logic [31:0]    mem_rdata;
   logic [31:0]    wb_data;
   logic [4:0]     wa;
   logic           dmem_we;
   logic [DAW-1:0] dmem_idx;
   logic [31:0]    dmem [0:DMEM_WORDS-1];

   mips_imem #(.WORDS(IMEM_WORDS)) imem (
      .addr_i  (pc_reg[IAW+1:2]),
      .rdata_o (instruction)
   );

   assign opcode = instruction[31:26];
   assign rs     = instruction[25:21];
   assign rt     = instruction[20:16];
   assign rd     = instruction[15:11];
   assign shamt  = instruction[10:6];
   assign funct  = instruction[5:0];
   assign imm    = instruction[15:0];

   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_we = 1'b1;
            ctrl.dst_rd = 1'b1;
            case (funct)
               FN_ADD:  ctrl.alu_op = ALU_ADD;
               FN_SUB:  ctrl.alu_op = ALU_SUB;
               FN_AND:  ctrl.alu_op = ALU_AND;
               FN_OR:   ctrl.alu_op = ALU_OR;
               FN_NOR:  ctrl.alu_op = ALU_NOR;
               FN_SLT:  ctrl.alu_op = ALU_SLT;
               FN_SLL:  ctrl.alu_op = ALU_SLL;
               FN_SRL:  ctrl.alu_op = ALU_SRL;
               FN_SRA:  ctrl.alu_op = ALU_SRA;
               default: ctrl.reg_we = 1'b0;
            endcase
         end
         OP_ADDI: begin
            ctrl.reg_we  = 1'b1;
            ctrl.use_imm = 1'b1;
         end
         OP_SLTI: begin
            ctrl.reg_we  = 1'b1;
            ctrl.use_imm = 1'b1;
            ctrl.alu_op  = ALU_SLT;
         end
         OP_ANDI: begin
            ctrl.reg_we   = 1'b1;
            ctrl.use_imm  = 1'b1;
            ctrl.zext_imm = 1'b1;
            ctrl.alu_op   = ALU_AND;
         end
         OP_ORI: begin
            ctrl.reg_we   = 1'b1;
            ctrl.use_imm  = 1'b1;
            ctrl.zext_imm = 1'b1;
            ctrl.alu_op   = ALU_OR;
         end
         OP_LUI: begin
            ctrl.reg_we = 1'b1;
            ctrl.alu_op = ALU_LUI;
         end
         OP_LW: begin
            ctrl.reg_we     = 1'b1;
            ctrl.use_imm    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            ctrl.mem_we  = 1'b1;
            ctrl.use_imm = 1'b1;
         end
         OP_BEQ:  ctrl.beq  = 1'b1;
         OP_BNE:  ctrl.bne  = 1'b1;
         OP_J:    ctrl.jump = 1'b1;
         default: ;
      endcase
   end

   mips_regfile REG_FILE (
      .clk_i  (clk),
      .rst_ni (reset),
      .ra1_i  (rs),
      .ra2_i  (rt),
      .rd1_o  (rs_val),
      .rd2_o  (rt_val),
      .we_i   (ctrl.reg_we),
      .wa_i   (wa),
      .wd_i   (wb_data)
   );

   assign imm_ext = ctrl.zext_imm ? {16'h0, imm} : {{16{imm[15]}}, imm};
   assign alu_b   = ctrl.use_imm ? imm_ext : rt_val;

   // Shifts always operate on rt with the shamt field, never on the immediate path.
   always_comb begin
      alu_res = '0;
      case (ctrl.alu_op)
         ALU_ADD: alu_res = rs_val + alu_b;
         ALU_SUB: alu_res = rs_val - alu_b;
         ALU_AND: alu_res = rs_val & alu_b;
         ALU_OR:  alu_res = rs_val | alu_b;
         ALU_NOR: alu_res = ~(rs_val | alu_b);
         ALU_SLT: alu_res = {31'h0, $signed(rs_val) < $signed(alu_b)};
         ALU_SLL: alu_res = rt_val << shamt;
         ALU_SRL: alu_res = rt_val >> shamt;
         ALU_SRA: alu_res = $signed(rt_val) >>> shamt;
         ALU_LUI: alu_res = {imm, 16'h0};
         default: alu_res = '0;
      endcase
   end

   assign dmem_idx  = alu_res[DAW+1:2];
   assign mem_rdata = dmem[dmem_idx];
   assign dmem_we   = ctrl.mem_we & reset;

   always_ff @(posedge clk) begin
      if (dmem_we) begin
         dmem[dmem_idx] <= rt_val;
      end
   end

   assign wa      = ctrl.dst_rd ? rd : rt;
   assign wb_data = ctrl.mem_to_reg ? mem_rdata : alu_res;

   always_comb begin
      pc_plus4 = pc_reg + 32'd4;
      pc_d     = pc_plus4;
      if ((ctrl.beq && (rs_val == rt_val)) || (ctrl.bne && (rs_val != rt_val))) begin
         pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
      end else if (ctrl.jump) begin
         pc_d = {pc_plus4[31:28], instruction[25:0], 2'b00};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg <= '0;
      end else begin
         pc_reg <= pc_d;
      end
   end

endmodule

// File: tb/tb_mips_processor.sv
// tb/tb_mips_processor.sv - instruction-set reference model bench for mips_processor
module tb_mips_processor;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   mips_processor #(.IMEM_WORDS(1024), .DMEM_WORDS(256)) dut (
      .clk   (clk),
      .reset (reset)
   );

   int          tests = 0;
   int          fails = 0;
   bit          cmp_en = 1'b0;
   logic [31:0] m_imem [0:1023];
   logic [31:0] m_dmem [0:255];
   logic [31:0] m_regs [0:31];
   logic [31:0] m_pc;
   logic [31:0] prog [$];
   logic [31:0] exp1 [0:7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] r_ins(input int fn, input int rs, input int rt, input int rd, input int sh);
      r_ins = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
      i_ins = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] j_ins(input int tgt);
      j_ins = {6'h02, 26'(tgt)};
   endfunction

   // Architectural effect of one instruction on the model state.
   task automatic model_step();
      logic [31:0] ins, a, b, se, ze, res, npc, addr;
      logic [4:0]  wr;
      bit          we;
      ins  = m_imem[m_pc[11:2]];
      a    = m_regs[ins[25:21]];
      b    = m_regs[ins[20:16]];
      se   = {{16{ins[15]}}, ins[15:0]};
      ze   = {16'h0, ins[15:0]};
      addr = a + se;
      npc  = m_pc + 32'd4;
      we   = 1'b0;
      wr   = ins[20:16];
      res  = 32'h0;
      case (ins[31:26])
         6'h00: begin
            wr = ins[15:11];
            we = 1'b1;
            case (ins[5:0])
               6'h20:   res = a + b;
               6'h22:   res = a - b;
               6'h24:   res = a & b;
               6'h25:   res = a | b;
               6'h27:   res = ~(a | b);
               6'h2A:   res = {31'h0, $signed(a) < $signed(b)};
               6'h00:   res = b << ins[10:6];
               6'h02:   res = b >> ins[10:6];
               6'h03:   res = $signed(b) >>> ins[10:6];
               default: we = 1'b0;
            endcase
         end
         6'h08: begin res = a + se; we = 1'b1; end
         6'h0A: begin res = {31'h0, $signed(a) < $signed(se)}; we = 1'b1; end
         6'h0C: begin res = a & ze; we = 1'b1; end
         6'h0D: begin res = a | ze; we = 1'b1; end
         6'h0F: begin res = {ins[15:0], 16'h0}; we = 1'b1; end
         6'h23: begin res = m_dmem[addr[9:2]]; we = 1'b1; end
         6'h2B: m_dmem[addr[9:2]] = b;
         6'h04: if (a == b) npc = m_pc + 32'd4 + {se[29:0], 2'b00};
         6'h05: if (a != b) npc = m_pc + 32'd4 + {se[29:0], 2'b00};
         6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
         default: ;
      endcase
      if (we && (wr != 5'd0)) m_regs[wr] = res;
      m_pc = npc;
   endtask

   task automatic model_reset();
      m_pc = 32'h0;
      for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
   endtask

   always @(posedge clk) begin
      if (reset) model_step();
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("pc", dut.pc_reg, m_pc);
         chk("instruction", dut.instruction, m_imem[m_pc[11:2]]);
         for (int r = 0; r < 32; r++) begin
            chk($sformatf("reg%0d", r), dut.REG_FILE.registers[r], m_regs[r]);
         end
      end
   end

   task automatic load_prog();
      logic [31:0] w;
      for (int i = 0; i < 1024; i++) begin
         w = (i < prog.size()) ? prog[i] : 32'h0;
         dut.imem.memory[i] = w;
         m_imem[i] = w;
      end
   endtask

   task automatic assert_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      model_reset();
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic run_trace(input string tag, input logic [31:0] tr [$]);
      for (int i = 0; i < tr.size(); i++) begin
         chk($sformatf("%s_pc%0d", tag, i), dut.pc_reg, tr[i]);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_prog1(input string tag);
      for (int r = 1; r < 8; r++) begin
         chk($sformatf("%s_r%0d", tag, r), dut.REG_FILE.registers[r], exp1[r]);
      end
   endtask

   task automatic build_prog1(input bit use_bne);
      prog = {};
      prog.push_back(i_ins(8'h08, 0, 1, 10));
      prog.push_back(i_ins(8'h08, 0, 2, 20));
      prog.push_back(r_ins(8'h20, 1, 2, 3, 0));
      prog.push_back(i_ins(8'h2B, 0, 3, 8));
      prog.push_back(i_ins(8'h23, 0, 4, 8));
      prog.push_back(r_ins(8'h22, 1, 2, 5, 0));
      prog.push_back(i_ins(use_bne ? 5 : 4, 4, 3, 2));
      prog.push_back(j_ins(9));
      prog.push_back(r_ins(8'h25, 4, 1, 4, 0));
      prog.push_back(r_ins(8'h2A, 1, 4, 6, 0));
      prog.push_back(r_ins(8'h27, 4, 6, 7, 0));
   endtask

   function automatic int rfn(input int k);
      case (k)
         0:       rfn = 'h20;
         1:       rfn = 'h22;
         2:       rfn = 'h24;
         3:       rfn = 'h25;
         4:       rfn = 'h27;
         5:       rfn = 'h2A;
         6:       rfn = 'h00;
         7:       rfn = 'h02;
         default: rfn = 'h03;
      endcase
   endfunction

   function automatic logic [31:0] rand_ins();
      int sel, rs, rt, rd;
      sel = int'($urandom_range(0, 19));
      rs  = int'($urandom_range(0, 7));
      rt  = int'($urandom_range(0, 7));
      rd  = int'($urandom_range(0, 7));
      case (sel)
         0, 1, 2, 3, 4, 5: rand_ins = r_ins(rfn(int'($urandom_range(0, 8))), rs, rt, rd, int'($urandom_range(0, 31)));
         6:       rand_ins = i_ins('h08, rs, rt, int'($urandom_range(0, 65535)));
         7:       rand_ins = i_ins('h0A, rs, rt, int'($urandom_range(0, 65535)));
         8:       rand_ins = i_ins('h0C, rs, rt, int'($urandom_range(0, 65535)));
         9:       rand_ins = i_ins('h0D, rs, rt, int'($urandom_range(0, 65535)));
         10:      rand_ins = i_ins('h0F, 0, rt, int'($urandom_range(0, 65535)));
         11, 12:  rand_ins = i_ins('h23, 0, rt, int'($urandom_range(0, 63)));
         13, 14:  rand_ins = i_ins('h2B, 0, rt, int'($urandom_range(0, 63)));
         15:      rand_ins = i_ins('h04, rs, rt, int'($urandom_range(0, 6)) - 2);
         16:      rand_ins = i_ins('h05, rs, rt, int'($urandom_range(0, 6)) - 2);
         17:      rand_ins = j_ins(int'($urandom_range(16, 55)));
         18:      rand_ins = i_ins('h3F, rs, rt, int'($urandom_range(0, 65535)));
         default: rand_ins = r_ins('h3F, rs, rt, rd, 0);
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tr [$];
      exp1[0] = 32'h0;
      exp1[1] = 32'd10;
      exp1[2] = 32'd20;
      exp1[3] = 32'd30;
      exp1[4] = 32'd30;
      exp1[5] = 32'hFFFF_FFF6;
      exp1[6] = 32'd1;
      exp1[7] = 32'hFFFF_FFE0;

      #1 reset = 1'b0;
      model_reset();
      #1;
      chk("reset_pc", dut.pc_reg, 32'h0);
      chk("reset_r31", dut.REG_FILE.registers[31], 32'h0);

      // Taken beq skips j/or.
      build_prog1(1'b0);
      load_prog();
      cmp_en = 1'b1;
      release_reset();
      tr = {32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd36, 32'd40};
      run_trace("beq", tr);
      repeat (2) @(posedge clk);
      #1;
      check_prog1("prog1");
      chk("prog1_dmem2", dut.dmem[2], 32'd30);

      // Mid-program asynchronous reset, then rerun.
      assert_reset();
      release_reset();
      repeat (5) @(posedge clk);
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk("midrst_pc", dut.pc_reg, 32'h0);
      for (int r = 1; r < 8; r++) chk($sformatf("midrst_r%0d", r), dut.REG_FILE.registers[r], 32'h0);
      release_reset();
      repeat (11) @(posedge clk);
      #1;
      check_prog1("rerun");

      // Not-taken bne falls into the jump.
      assert_reset();
      build_prog1(1'b1);
      load_prog();
      release_reset();
      tr = {32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd36, 32'd40};
      run_trace("bne", tr);
      @(posedge clk);
      #1;
      check_prog1("bne");

      // $0 write discarded.
      assert_reset();
      prog = {};
      prog.push_back(i_ins('h08, 0, 1, 7));
      prog.push_back(i_ins('h08, 0, 0, 5));
      prog.push_back(r_ins('h20, 0, 0, 1, 0));
      load_prog();
      release_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("zero_r0", dut.REG_FILE.registers[0], 32'h0);
      chk("zero_r1", dut.REG_FILE.registers[1], 32'h0);

      // Immediates, shifts, compares and undefined encodings.
      assert_reset();
      prog = {};
      prog.push_back(i_ins('h0F, 0, 1, 'h1234));
      prog.push_back(i_ins('h0D, 1, 1, 'h5678));
      prog.push_back(r_ins('h03, 0, 1, 2, 4));
      prog.push_back(i_ins('h08, 0, 3, -1));
      prog.push_back(r_ins('h02, 0, 3, 4, 28));
      prog.push_back(i_ins('h0F, 0, 6, 'h8000));
      prog.push_back(r_ins('h03, 0, 6, 7, 4));
      prog.push_back(r_ins('h02, 0, 6, 8, 4));
      prog.push_back(r_ins('h00, 0, 1, 9, 4));
      prog.push_back(i_ins('h0C, 3, 10, 'hFFFF));
      prog.push_back(i_ins('h3F, 0, 10, 1));
      prog.push_back(r_ins('h3F, 1, 1, 10, 0));
      prog.push_back(i_ins('h0A, 3, 11, 0));
      prog.push_back(i_ins('h0A, 1, 12, -1));
      prog.push_back(i_ins('h08, 3, 13, 2));
      prog.push_back(r_ins('h22, 0, 3, 14, 0));
      load_prog();
      release_reset();
      repeat (16) @(posedge clk);
      #1;
      chk("lui_ori_r1", dut.REG_FILE.registers[1], 32'h1234_5678);
      chk("sra_r2", dut.REG_FILE.registers[2], 32'h0123_4567);
      chk("addi_neg_r3", dut.REG_FILE.registers[3], 32'hFFFF_FFFF);
      chk("srl_r4", dut.REG_FILE.registers[4], 32'd15);
      chk("sra_neg_r7", dut.REG_FILE.registers[7], 32'hF800_0000);
      chk("srl_r8", dut.REG_FILE.registers[8], 32'h0800_0000);
      chk("sll_r9", dut.REG_FILE.registers[9], 32'h2345_6780);
      chk("andi_zext_r10", dut.REG_FILE.registers[10], 32'h0000_FFFF);
      chk("slti_r11", dut.REG_FILE.registers[11], 32'd1);
      chk("slti_r12", dut.REG_FILE.registers[12], 32'd0);
      chk("addi_wrap_r13", dut.REG_FILE.registers[13], 32'd1);
      chk("sub_wrap_r14", dut.REG_FILE.registers[14], 32'd1);

      // Random programs; data region 0..63 is zeroed first so every load is defined.
      for (int p = 0; p < 6; p++) begin
         assert_reset();
         prog = {};
         for (int k = 0; k < 16; k++) prog.push_back(i_ins('h2B, 0, 0, 4 * k));
         for (int k = 0; k < 40; k++) prog.push_back(rand_ins());
         load_prog();
         release_reset();
         repeat (90) @(posedge clk);
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
